// File: rtl/mod2011_reduce_seq.sv
// -----------------------------------------------------------------------------
// mod2011_reduce_seq
//
// Sequential modular reducer: out_data = in_data mod MOD (2011 by default).
// The operand is walked one 6-bit chunk per cycle, least significant first.
// Each chunk is sent to an external LUT bank, which returns
// (chunk * 2^(6*idx)) mod MOD. The returned values are summed mod MOD.
//
// Handshakes:
//   - in_valid/in_ready accept one operand while the block is IDLE.
//   - out_valid/out_ready hand over the residue. The residue is held stable
//     in DONE until the consumer takes it.
//
// Build option:
//   EARLY_TERM_EN - when defined, RUN ends as soon as the remaining
//                   (unshifted) chunks are all zero. The residue is the same;
//                   only the latency shrinks. When undefined, RUN always
//                   lasts NCHUNK cycles.
// -----------------------------------------------------------------------------
module mod2011_reduce_seq #(
    parameter int MOD    = 2011,
    parameter int NCHUNK = 16,
    parameter int RES_W  = 11,
    parameter int IDX_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // operand side
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [6*NCHUNK-1:0]   in_data,
    // chunk-LUT bank
    output logic [IDX_W-1:0]      lut_idx,
    output logic [5:0]            lut_chunk,
    input  logic [RES_W-1:0]      lut_val,
    // residue side
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [RES_W-1:0]      out_data,
    output logic                  busy
);

    localparam int                IN_W   = 6 * NCHUNK;
    localparam logic [RES_W:0]    L_MOD  = (RES_W + 1)'(MOD);
    localparam logic [IDX_W-1:0]  L_LAST = IDX_W'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t             r_state;
    logic [IN_W-1:0]    r_opr;        // operand, shifted right one chunk per RUN cycle
    logic [IDX_W-1:0]   r_idx;        // position of the chunk in r_opr[5:0]
    logic [RES_W-1:0]   r_acc;        // running residue, always < MOD
    logic [RES_W-1:0]   r_out_data;
    logic               r_out_valid;

    // -------------------------------------------------------------------------
    // Combinational datapath
    // -------------------------------------------------------------------------
    state_t             w_state_next;
    logic [IN_W-1:0]    w_opr_shift;
    logic [RES_W:0]     w_sum;
    logic               w_sum_ge_mod;
    logic [RES_W-1:0]   w_acc_next;
    logic               w_last;
    logic               w_run_end;

    assign w_opr_shift = r_opr >> 6;

    // Both addends are below MOD, so their sum is below 2*MOD and one
    // conditional subtraction brings it back into range. The extra bit
    // keeps the carry of the addition.
    assign w_sum        = {1'b0, r_acc} + {1'b0, lut_val};
    assign w_sum_ge_mod = (w_sum >= L_MOD);
    assign w_acc_next   = w_sum_ge_mod ? RES_W'(w_sum - L_MOD) : w_sum[RES_W-1:0];

    assign w_last = (r_idx == L_LAST);

`ifdef EARLY_TERM_EN
    // Once every chunk still to come is zero, their contribution is zero and
    // the accumulated residue is already final.
    logic w_rest_zero;
    assign w_rest_zero = (w_opr_shift == '0);
    assign w_run_end   = w_last || w_rest_zero;
`else
    assign w_run_end   = w_last;
`endif

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    // NOTE: every clocked assignment uses <= so all registers update from the
    // values present before the edge, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next state and decoded outputs
    // -------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        busy         = 1'b0;
        lut_idx      = '0;
        lut_chunk    = '0;

        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = RUN;
                end
            end

            RUN: begin
                busy      = 1'b1;
                lut_idx   = r_idx;
                lut_chunk = r_opr[5:0];
                if (w_run_end) begin
                    w_state_next = DONE;
                end
            end

            DONE: begin
                busy = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Operand shift register, chunk index, accumulator and result registers
    // -------------------------------------------------------------------------
    // NOTE: the wide operand register is reset as well: a reset in the middle
    // of an operation must leave no trace of the discarded operand.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opr       <= '0;
            r_idx       <= '0;
            r_acc       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_opr <= in_data;
                        r_idx <= '0;
                        r_acc <= '0;
                    end
                end

                RUN: begin
                    r_opr <= w_opr_shift;
                    r_acc <= w_acc_next;
                    if (w_run_end) begin
                        r_idx       <= '0;
                        r_out_data  <= w_acc_next;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end

                default: begin
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

    // -------------------------------------------------------------------------
    // Interface properties
    // -------------------------------------------------------------------------
    // A stalled residue must stay valid and unchanged.
    a_out_stable : assert property (
        @(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data))
    );

    // The bank must return a reduced value while it is being used.
    a_lut_range : assert property (
        @(posedge clk) disable iff (!rst_n)
        (r_state == RUN) |-> (lut_val < L_MOD)
    );

    // The chunk index never walks past the last chunk.
    a_idx_range : assert property (
        @(posedge clk) disable iff (!rst_n)
        (r_idx <= L_LAST)
    );

endmodule

// File: tb/tb_mod2011_reduce_seq.sv
// -----------------------------------------------------------------------------
// tb_mod2011_reduce_seq
//
// Directed and random checks of mod2011_reduce_seq. The LUT bank is modelled
// by repeated doubling mod 2011; the golden residue uses a wide % operator.
// Latency expectations follow EARLY_TERM_EN when the bench is built with it.
// -----------------------------------------------------------------------------
module tb_mod2011_reduce_seq;

    localparam int MOD    = 2011;
    localparam int NCHUNK = 16;
    localparam int RES_W  = 11;
    localparam int IDX_W  = 4;
    localparam int IN_W   = 6 * NCHUNK;
    localparam int BUDGET = 200;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_data;
    logic [IDX_W-1:0]  lut_idx;
    logic [5:0]        lut_chunk;
    logic [RES_W-1:0]  lut_val;
    logic              out_valid;
    logic              out_ready;
    logic [RES_W-1:0]  out_data;
    logic              busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    mod2011_reduce_seq #(
        .MOD    (MOD),
        .NCHUNK (NCHUNK),
        .RES_W  (RES_W),
        .IDX_W  (IDX_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .lut_idx   (lut_idx),
        .lut_chunk (lut_chunk),
        .lut_val   (lut_val),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // LUT bank model: (chunk * 2^(6*idx)) mod MOD.
    function automatic logic [RES_W-1:0] lut_model(input logic [IDX_W-1:0] idx,
                                                   input logic [5:0] chunk);
        int p;
        p = 1;
        for (int i = 0; i < 6 * int'(idx); i++) p = (p * 2) % MOD;
        return RES_W'((int'(chunk) * p) % MOD);
    endfunction

    always_comb lut_val = lut_model(lut_idx, lut_chunk);

    function automatic logic [RES_W-1:0] golden(input logic [IN_W-1:0] x);
        logic [IN_W-1:0] r;
        r = x % IN_W'(MOD);
        return r[RES_W-1:0];
    endfunction

    // Cycles from accept (T) to the first cycle with out_valid high.
    function automatic int exp_lat(input logic [IN_W-1:0] x);
`ifdef EARLY_TERM_EN
        int h;
        h = -1;
        for (int i = 0; i < NCHUNK; i++) if (x[6*i +: 6] != 6'd0) h = i;
        return (h < 0) ? 2 : h + 2;
`else
        return NCHUNK + 1;
`endif
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Present an operand, wait for in_ready, let one edge accept it.
    task automatic send(input logic [IN_W-1:0] d, output int acc_cyc);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && t < BUDGET) begin
            step;
            t++;
        end
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send_ready_timeout: in_ready=%b required 1", in_ready);
        end
        step;
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    // Called right after the accept edge; returns latency in cycles.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < BUDGET) begin
            step;
            lat++;
        end
        n_tests++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL out_valid_timeout: out_valid=%b required 1", out_valid);
        end
    endtask

    task automatic collect;
        out_ready = 1'b1;
        step;
        out_ready = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #1;
        n_tests++; if (in_ready  !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b exp 1", in_ready); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b exp 0", out_valid); end
        n_tests++; if (out_data  !== '0)   begin n_fail++; $display("FAIL rst_out_data: got %0d exp 0", out_data); end
        n_tests++; if (busy      !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b exp 0", busy); end
        n_tests++; if (lut_idx   !== '0)   begin n_fail++; $display("FAIL rst_lut_idx: got %0d exp 0", lut_idx); end
        n_tests++; if (lut_chunk !== '0)   begin n_fail++; $display("FAIL rst_lut_chunk: got %0d exp 0", lut_chunk); end
        step;
        step;
        rst_n = 1'b1;
        step;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_in_ready: got %b exp 1", in_ready); end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_directed;
        logic [IN_W-1:0]  ops [4];
        logic [RES_W-1:0] exp [4];
        int ac, lat;
        ops[0] = 96'd0;    exp[0] = 11'd0;
        ops[1] = 96'd6038; exp[1] = 11'd5;
        ops[2] = 96'd2010; exp[2] = 11'd2010;
        ops[3] = 96'd4096; exp[3] = 11'd74;
        for (int k = 0; k < 4; k++) begin
            send(ops[k], ac);
            wait_valid(lat);
            n_tests++;
            if (out_data !== exp[k]) begin
                n_fail++;
                $display("FAIL directed_data[%0d]: got %0d exp %0d", k, out_data, exp[k]);
            end
            n_tests++;
            if (lat != exp_lat(ops[k])) begin
                n_fail++;
                $display("FAIL directed_latency[%0d]: got %0d exp %0d", k, lat, exp_lat(ops[k]));
            end
            collect;
        end
    endtask

    // Chunk i holds i+1, so the bank is walked through every position.
    task automatic test_lut_drive;
        logic [IN_W-1:0] d;
        int ac;
        d = '0;
        for (int i = 0; i < NCHUNK; i++) d[6*i +: 6] = 6'(i + 1);
        send(d, ac);
        for (int i = 0; i < NCHUNK; i++) begin
            n_tests++;
            if (lut_idx !== IDX_W'(i) || lut_chunk !== 6'(i + 1) || busy !== 1'b1 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL lut_drive[%0d]: idx=%0d chunk=%0d busy=%b in_ready=%b exp idx=%0d chunk=%0d busy=1 in_ready=0",
                         i, lut_idx, lut_chunk, busy, in_ready, i, i + 1);
            end
            step;
        end
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== golden(d)) begin
            n_fail++;
            $display("FAIL lut_drive_result: valid=%b data=%0d exp valid=1 data=%0d", out_valid, out_data, golden(d));
        end
        collect;
        n_tests++;
        if (lut_idx !== '0 || lut_chunk !== '0) begin
            n_fail++;
            $display("FAIL lut_idle_zero: idx=%0d chunk=%0d exp 0 0", lut_idx, lut_chunk);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_random;
        logic [IN_W-1:0] d;
        int ac, lat;
        for (int k = 0; k < 201; k++) begin
            d = (k == 0) ? '1 : {$urandom, $urandom, $urandom};
            send(d, ac);
            wait_valid(lat);
            n_tests++;
            if (out_data !== golden(d)) begin
                n_fail++;
                $display("FAIL random[%0d] in=%h: got %0d exp %0d", k, d, out_data, golden(d));
            end
            collect;
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_backpressure;
        int ac, lat;
        send(96'd6038, ac);
        wait_valid(lat);
        in_valid = 1'b1;
        in_data  = 96'd1;
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== 11'd5 || in_ready !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL backpressure[%0d]: valid=%b data=%0d in_ready=%b busy=%b exp 1 5 0 1",
                         i, out_valid, out_data, in_ready, busy);
            end
            step;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step;
        out_ready = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_release: valid=%b in_ready=%b busy=%b exp 0 1 0", out_valid, in_ready, busy);
        end
        // out_ready while nothing is pending changes nothing.
        out_ready = 1'b1;
        step;
        out_ready = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stray_out_ready: valid=%b in_ready=%b exp 0 1", out_valid, in_ready);
        end
        send(96'd2010, ac);
        wait_valid(lat);
        n_tests++;
        if (out_data !== 11'd2010) begin
            n_fail++;
            $display("FAIL backpressure_next: got %0d exp 2010", out_data);
        end
        collect;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset_mid;
        int ac, lat;
        send('1, ac);
        for (int i = 0; i < 6; i++) step;
        n_tests++;
        if (lut_idx !== IDX_W'(6) || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_run_position: idx=%0d busy=%b exp 6 1", lut_idx, busy);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || lut_idx !== '0 || lut_chunk !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_async: in_ready=%b busy=%b valid=%b idx=%0d chunk=%0d exp 1 0 0 0 0",
                     in_ready, busy, out_valid, lut_idx, lut_chunk);
        end
        step;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            n_tests++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL mid_reset_quiet[%0d]: valid=%b in_ready=%b exp 0 1", i, out_valid, in_ready);
            end
            step;
        end
        send(96'd2011, ac);
        wait_valid(lat);
        n_tests++;
        if (out_data !== 11'd0) begin
            n_fail++;
            $display("FAIL mid_reset_next: got %0d exp 0", out_data);
        end
        collect;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_back_to_back;
        logic [IN_W-1:0] ops [3];
        int acc_cyc [3];
        int t, lat;
        ops[0] = 96'd1;
        ops[1] = 96'd2012;
        ops[2] = 96'd4023;
        in_valid  = 1'b1;
        in_data   = ops[0];
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            t = 0;
            while (!in_ready && t < BUDGET) begin
                step;
                t++;
            end
            n_tests++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_ready_timeout[%0d]: in_ready=%b exp 1", k, in_ready);
            end
            step;
            acc_cyc[k] = cyc;
            if (k < 2) in_data = ops[k + 1];
            else       in_valid = 1'b0;
            wait_valid(lat);
            n_tests++;
            if (out_data !== 11'd1) begin
                n_fail++;
                $display("FAIL b2b_data[%0d]: got %0d exp 1", k, out_data);
            end
            n_tests++;
            if (lat != exp_lat(ops[k])) begin
                n_fail++;
                $display("FAIL b2b_latency[%0d]: got %0d exp %0d", k, lat, exp_lat(ops[k]));
            end
            step;
            n_tests++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_idle[%0d]: valid=%b in_ready=%b exp 0 1", k, out_valid, in_ready);
            end
        end
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (acc_cyc[k + 1] - acc_cyc[k] != exp_lat(ops[k]) + 1) begin
                n_fail++;
                $display("FAIL b2b_gap[%0d]: got %0d exp %0d", k, acc_cyc[k + 1] - acc_cyc[k], exp_lat(ops[k]) + 1);
            end
        end
    endtask

    // -------------------------------------------------------------------------
    initial begin
        test_reset;
        test_directed;
        test_lut_drive;
        test_random;
        test_backpressure;
        test_reset_mid;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
